// File: rtl/alu_idecode_memory.sv
// -----------------------------------------------------------------------------
// alu_idecode_memory
//
// Fetch/decode/execute slice of the single-cycle RV32I teaching core.
// A small word-addressed memory supplies the instruction word. That word is
// split into register indices and a sign-extended immediate. The OP-IMM or
// LUI result is computed from that immediate and the rs1 value.
//
// Ports
//   clk              in   1   clock, rising edge
//   rst              in   1   asynchronous active-high reset (clears memory)
//   mem_write_enable in   1   write mem_data_in at mem_address on clk rise
//   mem_address      in   32  word index (pc >> 2), not a byte address
//   mem_data_in      in   32  write data
//   rs1_value        in   32  register-file read of rs1
//   instr            out  32  memory word at mem_address (combinational)
//   opcode           out  7   instr[6:0]
//   rd               out  5   instr[11:7]
//   funct3           out  3   instr[14:12]
//   rs1              out  5   instr[19:15]
//   rs2              out  5   instr[24:20]
//   imm_value        out  32  decoded immediate
//   rd_value         out  32  ALU result
//   reg_write        out  1   high for OP-IMM and LUI
// -----------------------------------------------------------------------------
module alu_idecode_memory #(
    parameter int SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data_in,
    input  logic [31:0] rs1_value,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm_value,
    output logic [31:0] rd_value,
    output logic        reg_write
);

    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // ------------------------------------------------------------------
    // Memory: synchronous write, combinational read.
    // The reset clears every word asynchronously, so the array cannot map
    // onto block RAM. At this size it is only a handful of registers.
    // ------------------------------------------------------------------
    logic [31:0]   mem_reg [SIZE];
    logic          addr_in_range;
    logic [AW-1:0] mem_index;

    // The full 32-bit compare keeps high address bits from aliasing onto
    // low words. There is no wrap-around.
    assign addr_in_range = (mem_address < 32'(SIZE));
    assign mem_index     = mem_address[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (mem_write_enable && addr_in_range) begin
            mem_reg[mem_index] <= mem_data_in;
        end
    end

    // During a write cycle the old word is read, because the array only
    // changes at the clock edge.
    assign instr = addr_in_range ? mem_reg[mem_index] : '0;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    always_comb begin
        imm_value = '0;
        unique case (opcode)
            OPC_OP_IMM: imm_value = {{20{instr[31]}}, instr[31:20]};
            OPC_LUI:    imm_value = {instr[31:12], 12'b0};
            default:    imm_value = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [4:0] shamt;
    logic       slt_signed;
    logic       slt_unsigned;

    assign shamt        = imm_value[4:0];
    assign slt_signed   = ($signed(rs1_value) < $signed(imm_value));
    assign slt_unsigned = (rs1_value < imm_value);

    always_comb begin
        rd_value  = '0;
        reg_write = 1'b0;
        if (opcode == OPC_OP_IMM) begin
            reg_write = 1'b1;
            unique case (funct3)
                3'b000: rd_value = rs1_value + imm_value;
                3'b010: rd_value = {31'b0, slt_signed};
                3'b011: rd_value = {31'b0, slt_unsigned};
                3'b100: rd_value = rs1_value ^ imm_value;
                3'b110: rd_value = rs1_value | imm_value;
                3'b111: rd_value = rs1_value & imm_value;
                3'b001: rd_value = rs1_value << shamt;
                // instr[30] selects the arithmetic or logical right shift.
                3'b101: rd_value = instr[30] ? 32'($signed(rs1_value) >>> shamt)
                                             : (rs1_value >> shamt);
                default: rd_value = '0;
            endcase
        end else if (opcode == OPC_LUI) begin
            reg_write = 1'b1;
            rd_value  = imm_value;
        end
    end

endmodule

// File: tb/tb_alu_idecode_memory.sv
// -----------------------------------------------------------------------------
// Testbench for alu_idecode_memory.
// Each stimulus step pushes its hand-computed expectation into a queue and
// raises a sample event. A separate monitor pops the expectation and compares
// it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_alu_idecode_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write_enable = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_data_in = '0;
    logic [31:0] rs1_value = '0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_value;
    logic [31:0] rd_value;
    logic        reg_write;

    alu_idecode_memory #(.SIZE(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .rs1_value        (rs1_value),
        .instr            (instr),
        .opcode           (opcode),
        .rd               (rd),
        .funct3           (funct3),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm_value        (imm_value),
        .rd_value         (rd_value),
        .reg_write        (reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] rd_value;
        logic        reg_write;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: pop one expectation per sample event and compare every output.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor actual=sample_with_empty_queue expected=queued_entry");
            end else begin
                e = exp_q.pop_front();
                cmp(e.name, "instr",     instr,               e.instr);
                cmp(e.name, "opcode",    {25'b0, opcode},     {25'b0, e.instr[6:0]});
                cmp(e.name, "rd",        {27'b0, rd},         {27'b0, e.instr[11:7]});
                cmp(e.name, "funct3",    {29'b0, funct3},     {29'b0, e.instr[14:12]});
                cmp(e.name, "rs1",       {27'b0, rs1},        {27'b0, e.instr[19:15]});
                cmp(e.name, "rs2",       {27'b0, rs2},        {27'b0, e.instr[24:20]});
                cmp(e.name, "imm",       imm_value,           e.imm);
                cmp(e.name, "rd_value",  rd_value,            e.rd_value);
                cmp(e.name, "reg_write", {31'b0, reg_write},  {31'b0, e.reg_write});
                $display("TXN %-10s addr=%0d instr=0x%08h imm=0x%08h rd_value=0x%08h reg_write=%0b",
                         e.name, mem_address, instr, imm_value, rd_value, reg_write);
            end
        end
    end

    // Present an address and rs1 value, then queue the expected response.
    // The task takes 2 ns, so it never straddles a clock edge when it is
    // called 1 ns after posedge or negedge.
    task automatic check(input string name, input logic [31:0] addr,
                         input logic [31:0] rs1v, input logic [31:0] e_instr,
                         input logic [31:0] e_imm, input logic [31:0] e_rdv,
                         input logic e_rw);
        exp_t e;
        mem_address = addr;
        rs1_value   = rs1v;
        e.name      = name;
        e.instr     = e_instr;
        e.imm       = e_imm;
        e.rd_value  = e_rdv;
        e.reg_write = e_rw;
        exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    // Write one word. The task returns 1 ns after the capturing edge.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        mem_write_enable = 1'b1;
        mem_address      = addr;
        mem_data_in      = data;
        @(posedge clk);
        #1;
        mem_write_enable = 1'b0;
    endtask

    initial begin
        #3;
        // Reset state: decode of an all-zero word.
        check("reset", 0, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;

        // andi x1,x0,0xFF
        write_word(0, 32'h0FF07093);
        check("andi", 0, 32'h12345678, 32'h0FF07093, 32'h000000FF, 32'h00000078, 1'b1);
        // addi x2,x0,-1
        write_word(1, 32'hFFF00113);
        check("addi_neg", 1, 32'd5, 32'hFFF00113, 32'hFFFFFFFF, 32'h00000004, 1'b1);
        // srai x3,x1,4
        write_word(3, 32'h4040D193);
        check("srai", 3, 32'h80000000, 32'h4040D193, 32'h00000404, 32'hF8000000, 1'b1);
        // srli x1,x2,4
        write_word(3, 32'h00415093);
        check("srli", 3, 32'h80000000, 32'h00415093, 32'h00000004, 32'h08000000, 1'b1);
        // slli x1,x2,8
        write_word(3, 32'h00811093);
        check("slli", 3, 32'h80000001, 32'h00811093, 32'h00000008, 32'h00000100, 1'b1);
        // slti x1,x2,-1: the signed compare differs from the unsigned one
        write_word(3, 32'hFFF12093);
        check("slti_t", 3, 32'h80000000, 32'hFFF12093, 32'hFFFFFFFF, 32'h1, 1'b1);
        check("slti_f", 3, 32'd5,        32'hFFF12093, 32'hFFFFFFFF, 32'h0, 1'b1);
        // sltiu x1,x2,-1
        write_word(3, 32'hFFF13093);
        check("sltiu", 3, 32'd5, 32'hFFF13093, 32'hFFFFFFFF, 32'h1, 1'b1);
        // xori / ori with 0x0F0
        write_word(3, 32'h0F014093);
        check("xori", 3, 32'h000000FF, 32'h0F014093, 32'h000000F0, 32'h0000000F, 1'b1);
        write_word(3, 32'h0F016093);
        check("ori", 3, 32'h0F00000F, 32'h0F016093, 32'h000000F0, 32'h0F0000FF, 1'b1);
        // addi x1,x2,1 wraps
        write_word(3, 32'h00110093);
        check("addi_wrap", 3, 32'hFFFFFFFF, 32'h00110093, 32'h00000001, 32'h0, 1'b1);
        // R-type add: not OP-IMM or LUI
        write_word(3, 32'h002081B3);
        check("rtype", 3, 32'h12345678, 32'h002081B3, 32'h0, 32'h0, 1'b0);
        // lui x1,0xABCDE
        write_word(4, 32'hABCDE0B7);
        check("lui", 4, 32'h12345678, 32'hABCDE0B7, 32'hABCDE000, 32'hABCDE000, 1'b1);

        // Out-of-range write is ignored, reads give zero, and nothing aliases.
        write_word(8, 32'hDEADBEEF);
        check("oob_read", 8, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("no_alias", 0, 32'h12345678, 32'h0FF07093, 32'h000000FF, 32'h00000078, 1'b1);

        // Read-during-write: the old value is seen before the edge.
        mem_write_enable = 1'b1;
        mem_data_in      = 32'h12345678;
        check("rdw_old", 2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        mem_write_enable = 1'b0;
        check("rdw_new", 2, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset between edges clears memory at once.
        rst = 1'b1;
        check("rst_async", 2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        // A write attempted while reset is held is blocked.
        write_word(1, 32'h0FF07093);
        check("rst_block", 1, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        check("post_rst", 4, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0);

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending expected=0_pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
